// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button debouncers, 100 Hz tick edge detector,
// IDLE/RUN/LAP/PAUSE sequencer and a 6-digit BCD MM:SS.cc time-base.
module stopwatch_ctrl #(
    parameter int DEB_CYCLES = 500000,
    parameter int TICK_SYNC  = 2
) (
    input  logic        clk_50mhz,
    input  logic        rst,
    input  logic        clk_100hz,
    input  logic        btn_start_stop,
    input  logic        btn_lap,
    input  logic        btn_clear,
    output logic [23:0] disp_bcd,
    output logic        running,
    output logic        lap_active,
    output logic        overflow,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        LAP   = 2'd2,
        PAUSE = 2'd3
    } state_t;

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
    localparam int BLAP = 0;
    localparam int BSS  = 1;
    localparam int BCLR = 2;

    logic [TICK_SYNC-1:0] tsync_q;
    logic                 tprev_q;
    logic                 tick;

    logic [2:0]    btn_raw;
    logic [2:0]    bmeta_q;
    logic [2:0]    bsync_q;
    logic [2:0]    stable_q;
    logic [2:0]    press_q;
    logic [CW-1:0] dcnt_q [3];

    logic ev_clr;
    logic ev_ss;
    logic ev_lap;

    state_t      state_q;
    logic [23:0] cnt_q;
    logic [23:0] cnt_d;
    logic [23:0] inc_v;
    logic [23:0] lap_q;
    logic [23:0] disp_q;
    logic        run_q;
    logic        lapa_q;
    logic        ovf_q;
    logic        ovf_d;
    logic        wrap;
    logic        cnt_en;
    logic        clr_act;

    // The 100 Hz wave is only ever sampled as data in the fast domain.
    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            tsync_q <= '0;
            tprev_q <= 1'b0;
        end else begin
            tsync_q <= {tsync_q[TICK_SYNC-2:0], clk_100hz};
            tprev_q <= tsync_q[TICK_SYNC-1];
        end
    end

    assign tick = tsync_q[TICK_SYNC-1] & ~tprev_q;

    assign btn_raw = {btn_clear, btn_start_stop, btn_lap};

    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            bmeta_q  <= '0;
            bsync_q  <= '0;
            stable_q <= '0;
            press_q  <= '0;
            for (int i = 0; i < 3; i++) begin
                dcnt_q[i] <= '0;
            end
        end else begin
            bmeta_q <= btn_raw;
            bsync_q <= bmeta_q;
            for (int i = 0; i < 3; i++) begin
                press_q[i] <= 1'b0;
                if (bsync_q[i] != stable_q[i]) begin
                    if (dcnt_q[i] == DEB_LAST) begin
                        stable_q[i] <= bsync_q[i];
                        dcnt_q[i]   <= '0;
                        press_q[i]  <= bsync_q[i];
                    end else begin
                        dcnt_q[i] <= dcnt_q[i] + CW'(1);
                    end
                end else begin
                    dcnt_q[i] <= '0;
                end
            end
        end
    end

    // Only the highest-priority event of a cycle survives.
    assign ev_clr = press_q[BCLR];
    assign ev_ss  = press_q[BSS] & ~press_q[BCLR];
    assign ev_lap = press_q[BLAP] & ~press_q[BSS] & ~press_q[BCLR];

    function automatic logic [24:0] bcd_inc(input logic [23:0] v);
        logic [23:0] r;
        logic        c;
        logic [3:0]  d;
        logic [3:0]  lim;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 6; i++) begin
            lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
            d   = v[4*i +: 4];
            if (c) begin
                if (d == lim) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = d + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return {c, r};
    endfunction

    always_comb begin
        {wrap, inc_v} = bcd_inc(cnt_q);
        cnt_en  = tick && (state_q == RUN || state_q == LAP);
        clr_act = ev_clr && (state_q == PAUSE);
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (clr_act) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (cnt_en) begin
            cnt_d = inc_v;
            ovf_d = ovf_q | wrap;
        end
    end

    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            run_q   <= 1'b0;
            lapa_q  <= 1'b0;
            lap_q   <= '0;
            disp_q  <= '0;
        end else begin
            disp_q <= (state_q == LAP) ? lap_q : cnt_q;
            unique case (state_q)
                IDLE: begin
                    if (ev_ss) begin
                        state_q <= RUN;
                        run_q   <= 1'b1;
                    end
                end
                RUN: begin
                    if (ev_ss) begin
                        state_q <= PAUSE;
                        run_q   <= 1'b0;
                    end else if (ev_lap) begin
                        state_q <= LAP;
                        lapa_q  <= 1'b1;
                        lap_q   <= cnt_q;
                    end
                end
                LAP: begin
                    if (ev_ss) begin
                        state_q <= PAUSE;
                        run_q   <= 1'b0;
                        lapa_q  <= 1'b0;
                    end else if (ev_lap) begin
                        state_q <= RUN;
                        lapa_q  <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (ev_ss) begin
                        state_q <= RUN;
                        run_q   <= 1'b1;
                    end else if (ev_clr) begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign disp_bcd   = disp_q;
    assign running    = run_q;
    assign lap_active = lapa_q;
    assign overflow   = ovf_q;
    assign state      = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: step table with a scoreboard of expected
// outputs, plus hand-written reset sequences.
module tb_stopwatch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        tclk;
    logic        b_ss;
    logic        b_lap;
    logic        b_clr;
    logic [23:0] disp_bcd;
    logic        running;
    logic        lap_active;
    logic        overflow;
    logic [1:0]  state;

    always #5 clk = ~clk;

    stopwatch_ctrl #(
        .DEB_CYCLES(4),
        .TICK_SYNC (2)
    ) dut (
        .clk_50mhz     (clk),
        .rst           (rst),
        .clk_100hz     (tclk),
        .btn_start_stop(b_ss),
        .btn_lap       (b_lap),
        .btn_clear     (b_clr),
        .disp_bcd      (disp_bcd),
        .running       (running),
        .lap_active    (lap_active),
        .overflow      (overflow),
        .state         (state)
    );

    typedef enum int {
        OP_SS, OP_LAP, OP_CLR, OP_BOTH, OP_TICKS, OP_BOUNCE, OP_PRELOAD
    } op_e;

    typedef struct {
        string       name;
        op_e         op;
        int          n;
        logic [1:0]  st;
        logic [23:0] disp;
        logic        run;
        logic        lap;
        logic        ovf;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(logic s, logic l, logic c);
        b_ss  = s;
        b_lap = l;
        b_clr = c;
        cyc(10);
        b_ss  = 1'b0;
        b_lap = 1'b0;
        b_clr = 1'b0;
        cyc(12);
    endtask

    task automatic ticks(int n);
        repeat (n) begin
            tclk = 1'b1;
            cyc(3);
            tclk = 1'b0;
            cyc(3);
        end
        cyc(3);
    endtask

    task automatic bounce();
        for (int i = 0; i < 10; i++) begin
            b_ss = ~b_ss;
            cyc(2);
        end
        b_ss = 1'b0;
        cyc(12);
    endtask

    task automatic preload();
        force dut.cnt_q = 24'h595999;
        cyc(2);
        release dut.cnt_q;
        cyc(3);
    endtask

    task automatic add(string nm, op_e op, int n, logic [1:0] st,
                       logic [23:0] d, logic r, logic l, logic o);
        vec_t v;
        v.name = nm;
        v.op   = op;
        v.n    = n;
        v.st   = st;
        v.disp = d;
        v.run  = r;
        v.lap  = l;
        v.ovf  = o;
        vecs.push_back(v);
    endtask

    task automatic compare_out();
        vec_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: empty queue");
        end else begin
            e = sb.pop_front();
            chk({e.name, " state"}, 32'(state), 32'(e.st));
            chk({e.name, " disp"}, 32'(disp_bcd), 32'(e.disp));
            chk({e.name, " running"}, 32'(running), 32'(e.run));
            chk({e.name, " lap_active"}, 32'(lap_active), 32'(e.lap));
            chk({e.name, " overflow"}, 32'(overflow), 32'(e.ovf));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        tclk  = 1'b0;
        b_ss  = 1'b0;
        b_lap = 1'b0;
        b_clr = 1'b0;

        add("start",       OP_SS,      0,   2'd1, 24'h000000, 1, 0, 0);
        add("ticks250",    OP_TICKS,   250, 2'd1, 24'h000250, 1, 0, 0);
        add("pause",       OP_SS,      0,   2'd3, 24'h000250, 0, 0, 0);
        add("pause_ticks", OP_TICKS,   50,  2'd3, 24'h000250, 0, 0, 0);
        add("clear",       OP_CLR,     0,   2'd0, 24'h000000, 0, 0, 0);
        add("bounce",      OP_BOUNCE,  0,   2'd0, 24'h000000, 0, 0, 0);
        add("start2",      OP_SS,      0,   2'd1, 24'h000000, 1, 0, 0);
        add("ticks500",    OP_TICKS,   500, 2'd1, 24'h000500, 1, 0, 0);
        add("lap",         OP_LAP,     0,   2'd2, 24'h000500, 1, 1, 0);
        add("lap_ticks",   OP_TICKS,   100, 2'd2, 24'h000500, 1, 1, 0);
        add("unlap",       OP_LAP,     0,   2'd1, 24'h000600, 1, 0, 0);
        add("clr_in_run",  OP_CLR,     0,   2'd1, 24'h000600, 1, 0, 0);
        add("run_ticks",   OP_TICKS,   5,   2'd1, 24'h000605, 1, 0, 0);
        add("pause2",      OP_SS,      0,   2'd3, 24'h000605, 0, 0, 0);
        add("ss_and_clr",  OP_BOTH,    0,   2'd0, 24'h000000, 0, 0, 0);
        add("idle_ticks",  OP_TICKS,   10,  2'd0, 24'h000000, 0, 0, 0);
        add("clr_idle",    OP_CLR,     0,   2'd0, 24'h000000, 0, 0, 0);
        add("start3",      OP_SS,      0,   2'd1, 24'h000000, 1, 0, 0);
        add("ticks100",    OP_TICKS,   100, 2'd1, 24'h000100, 1, 0, 0);
        add("lap2",        OP_LAP,     0,   2'd2, 24'h000100, 1, 1, 0);
        add("lap_ticks2",  OP_TICKS,   7,   2'd2, 24'h000100, 1, 1, 0);
        add("pause_lap",   OP_SS,      0,   2'd3, 24'h000107, 0, 0, 0);
        add("resume",      OP_SS,      0,   2'd1, 24'h000107, 1, 0, 0);
        add("tick1",       OP_TICKS,   1,   2'd1, 24'h000108, 1, 0, 0);
        add("pause3",      OP_SS,      0,   2'd3, 24'h000108, 0, 0, 0);
        add("preload",     OP_PRELOAD, 0,   2'd3, 24'h595999, 0, 0, 0);
        add("resume2",     OP_SS,      0,   2'd1, 24'h595999, 1, 0, 0);
        add("wrap",        OP_TICKS,   1,   2'd1, 24'h000000, 1, 0, 1);
        add("post_wrap",   OP_TICKS,   3,   2'd1, 24'h000003, 1, 0, 1);
        add("pause4",      OP_SS,      0,   2'd3, 24'h000003, 0, 0, 1);
        add("clear_ovf",   OP_CLR,     0,   2'd0, 24'h000000, 0, 0, 0);

        cyc(2);
        chk("reset state", 32'(state), 32'd0);
        chk("reset disp", 32'(disp_bcd), 32'd0);
        chk("reset running", 32'(running), 32'd0);
        chk("reset lap_active", 32'(lap_active), 32'd0);
        chk("reset overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        cyc(2);

        press(1'b1, 1'b0, 1'b0);
        ticks(1234);
        chk("midrun disp", 32'(disp_bcd), 32'h001234);
        chk("midrun running", 32'(running), 32'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async rst state", 32'(state), 32'd0);
        chk("async rst disp", 32'(disp_bcd), 32'd0);
        chk("async rst running", 32'(running), 32'd0);
        chk("async rst lap_active", 32'(lap_active), 32'd0);
        chk("async rst overflow", 32'(overflow), 32'd0);
        cyc(2);
        rst = 1'b0;
        cyc(2);

        b_ss = 1'b1;
        cyc(4);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(2);
        b_ss = 1'b0;
        cyc(12);
        chk("rst mid-debounce state", 32'(state), 32'd0);

        foreach (vecs[i]) begin
            sb.push_back(vecs[i]);
            case (vecs[i].op)
                OP_SS:      press(1'b1, 1'b0, 1'b0);
                OP_LAP:     press(1'b0, 1'b1, 1'b0);
                OP_CLR:     press(1'b0, 1'b0, 1'b1);
                OP_BOTH:    press(1'b1, 1'b0, 1'b1);
                OP_TICKS:   ticks(vecs[i].n);
                OP_BOUNCE:  bounce();
                OP_PRELOAD: preload();
                default:    cyc(1);
            endcase
            compare_out();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
